// File: rtl/sram_bridge_if.sv
// CPU-side MEM-stage data port of the SRAM bridge.
// The master modport is the pipeline, the slave modport is the bridge.
interface sram_bridge_if #(
    parameter int BUS_DW = 32
);
    logic                  en;
    logic                  we;
    logic [BUS_DW/8-1:0]   sel;
    logic [31:0]           addr;
    logic [BUS_DW-1:0]     wdata;
    logic [BUS_DW-1:0]     rdata;
    logic                  stallreq;
    logic                  done;

    modport master (
        output en, we, sel, addr, wdata,
        input  rdata, stallreq, done
    );

    modport slave (
        input  en, we, sel, addr, wdata,
        output rdata, stallreq, done
    );
endinterface

// File: rtl/sram_bridge.sv
// Multi-beat bridge from the CPU data port to a narrower asynchronous SRAM.
// Each bus access is split into SRAM_DW-wide beats; beats with no enabled
// byte lanes are skipped. Every beat is ACCESS (WAIT_CYCLES+1 cycles)
// followed by one RECOVER cycle that holds address, lanes and write data
// while the strobes are released.
module sram_bridge #(
    parameter int BUS_DW      = 32,
    parameter int SRAM_DW     = 16,
    parameter int SRAM_AW     = 19,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_bridge_if.slave           bus,
    output logic [SRAM_AW-1:0]     sram_addr,
    input  logic [SRAM_DW-1:0]     sram_data_i,
    output logic [SRAM_DW-1:0]     sram_data_o,
    output logic                   sram_data_oe,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic [SRAM_DW/8-1:0]   sram_be_n
);
    localparam int SB    = SRAM_DW / 8;
    localparam int BW    = BUS_DW / 8;
    localparam int BEATS = BUS_DW / SRAM_DW;
    localparam int LSB   = $clog2(SB);
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               state_r;
    logic [KW-1:0]        k_r;
    logic [3:0]           wc_r;
    logic                 we_r;
    logic [BW-1:0]        sel_r;
    logic [BUS_DW-1:0]    wdata_r;
    logic [SRAM_AW-1:0]   base_r;
    logic [BUS_DW-1:0]    rdata_r;
    logic                 done_r;

    logic [SRAM_AW-1:0]   base_in_s;
    logic                 first_found_s;
    logic [KW-1:0]        first_k_s;
    logic                 next_found_s;
    logic [KW-1:0]        next_k_s;
    logic [SB-1:0]        cur_lanes_s;
    logic [SRAM_DW-1:0]   cap_s;
    logic                 launch_found_s;
    logic [KW-1:0]        launch_k_s;
    logic                 launch_we_s;
    logic [SB-1:0]        launch_lanes_s;
    logic [SRAM_AW-1:0]   launch_addr_s;
    logic [SRAM_DW-1:0]   launch_data_s;
    logic                 unused_addr_s;

    // Byte-lane enables belonging to beat k.
    function automatic logic [SB-1:0] lanes(input logic [BW-1:0] s, input logic [KW-1:0] k);
        return s[int'(k)*SB +: SB];
    endfunction

    // Write data slice belonging to beat k.
    function automatic logic [SRAM_DW-1:0] beat_data(input logic [BUS_DW-1:0] d, input logic [KW-1:0] k);
        return d[int'(k)*SRAM_DW +: SRAM_DW];
    endfunction

    // SRAM word address of beat 0: bus-word aligned so beats are base+k.
    assign base_in_s     = bus.addr[SRAM_AW+LSB-1:LSB] & ~SRAM_AW'(BEATS - 1);
    assign unused_addr_s = ^bus.addr;

    assign bus.rdata    = rdata_r;
    assign bus.done     = done_r;
    assign bus.stallreq = ((state_r == ST_IDLE) && bus.en) ||
                          (state_r == ST_ACCESS) || (state_r == ST_RECOVER);

    // Lowest enabled beat of the incoming request.
    always_comb begin
        first_found_s = 1'b0;
        first_k_s     = {KW{1'b0}};
        for (int i = BEATS - 1; i >= 0; i--) begin
            if (lanes(bus.sel, KW'(i)) != {SB{1'b0}}) begin
                first_found_s = 1'b1;
                first_k_s     = KW'(i);
            end else begin
                first_found_s = first_found_s;
                first_k_s     = first_k_s;
            end
        end
    end

    // Next enabled beat above the current one for the latched request.
    always_comb begin
        next_found_s = 1'b0;
        next_k_s     = {KW{1'b0}};
        for (int i = BEATS - 1; i >= 0; i--) begin
            if ((i > int'(k_r)) && (lanes(sel_r, KW'(i)) != {SB{1'b0}})) begin
                next_found_s = 1'b1;
                next_k_s     = KW'(i);
            end else begin
                next_found_s = next_found_s;
                next_k_s     = next_k_s;
            end
        end
    end

    // Read capture: only enabled lanes pass, disabled lanes read as zero.
    always_comb begin
        cur_lanes_s = lanes(sel_r, k_r);
        cap_s       = {SRAM_DW{1'b0}};
        for (int b = 0; b < SB; b++) begin
            if (cur_lanes_s[b]) begin
                cap_s[b*8 +: 8] = sram_data_i[b*8 +: 8];
            end else begin
                cap_s[b*8 +: 8] = 8'h00;
            end
        end
    end

    // Beat to launch next: from the live bus in IDLE, from the latch otherwise.
    always_comb begin
        if (state_r == ST_IDLE) begin
            launch_found_s = first_found_s;
            launch_k_s     = first_k_s;
            launch_we_s    = bus.we;
            launch_lanes_s = lanes(bus.sel, first_k_s);
            launch_addr_s  = base_in_s | SRAM_AW'(first_k_s);
            launch_data_s  = beat_data(bus.wdata, first_k_s);
        end else begin
            launch_found_s = next_found_s;
            launch_k_s     = next_k_s;
            launch_we_s    = we_r;
            launch_lanes_s = lanes(sel_r, next_k_s);
            launch_addr_s  = base_r | SRAM_AW'(next_k_s);
            launch_data_s  = beat_data(wdata_r, next_k_s);
        end
    end

    // Access sequencer with registered SRAM strobes, rdata and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            k_r          <= {KW{1'b0}};
            wc_r         <= 4'd0;
            we_r         <= 1'b0;
            sel_r        <= {BW{1'b0}};
            wdata_r      <= {BUS_DW{1'b0}};
            base_r       <= {SRAM_AW{1'b0}};
            rdata_r      <= {BUS_DW{1'b0}};
            done_r       <= 1'b0;
            sram_addr    <= {SRAM_AW{1'b0}};
            sram_data_o  <= {SRAM_DW{1'b0}};
            sram_data_oe <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= {SB{1'b1}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.en) begin
                        we_r    <= bus.we;
                        sel_r   <= bus.sel;
                        wdata_r <= bus.wdata;
                        base_r  <= base_in_s;
                        rdata_r <= {BUS_DW{1'b0}};
                        if (launch_found_s) begin
                            state_r   <= ST_ACCESS;
                            k_r       <= launch_k_s;
                            wc_r      <= 4'd0;
                            sram_ce_n <= 1'b0;
                            sram_be_n <= ~launch_lanes_s;
                            sram_addr <= launch_addr_s;
                            if (launch_we_s) begin
                                sram_we_n    <= 1'b0;
                                sram_oe_n    <= 1'b1;
                                sram_data_oe <= 1'b1;
                                sram_data_o  <= launch_data_s;
                            end else begin
                                sram_we_n    <= 1'b1;
                                sram_oe_n    <= 1'b0;
                                sram_data_oe <= 1'b0;
                            end
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (wc_r == 4'(WAIT_CYCLES)) begin
                        state_r   <= ST_RECOVER;
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        if (!we_r) begin
                            rdata_r[int'(k_r)*SRAM_DW +: SRAM_DW] <= cap_s;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                    end else begin
                        wc_r <= wc_r + 4'd1;
                    end
                end
                ST_RECOVER: begin
                    if (launch_found_s) begin
                        state_r   <= ST_ACCESS;
                        k_r       <= launch_k_s;
                        wc_r      <= 4'd0;
                        sram_ce_n <= 1'b0;
                        sram_be_n <= ~launch_lanes_s;
                        sram_addr <= launch_addr_s;
                        if (launch_we_s) begin
                            sram_we_n    <= 1'b0;
                            sram_oe_n    <= 1'b1;
                            sram_data_oe <= 1'b1;
                            sram_data_o  <= launch_data_s;
                        end else begin
                            sram_we_n    <= 1'b1;
                            sram_oe_n    <= 1'b0;
                            sram_data_oe <= 1'b0;
                        end
                    end else begin
                        state_r      <= ST_DONE;
                        done_r       <= 1'b1;
                        sram_ce_n    <= 1'b1;
                        sram_be_n    <= {SB{1'b1}};
                        sram_data_oe <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    done_r       <= 1'b0;
                    sram_ce_n    <= 1'b1;
                    sram_oe_n    <= 1'b1;
                    sram_we_n    <= 1'b1;
                    sram_be_n    <= {SB{1'b1}};
                    sram_data_oe <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge: default 32/16 instance plus a 32/8,
// zero-wait instance. Expected values are hand-computed per cycle T0..Tn,
// where T0 is the cycle in which the request is presented in IDLE.
module tb_sram_bridge;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- instance 0: defaults ----------------
    sram_bridge_if #(.BUS_DW(32)) if0 ();
    logic [18:0] sram_addr0;
    logic [15:0] sram_data_i0, sram_data_o0;
    logic        sram_data_oe0, sram_ce_n0, sram_oe_n0, sram_we_n0;
    logic [1:0]  sram_be_n0;
    logic [15:0] mem0 [0:255];

    assign sram_data_i0 = sram_oe_n0 ? 16'h0000 : mem0[sram_addr0[7:0]];

    sram_bridge u0 (
        .clk(clk), .rst(rst), .bus(if0),
        .sram_addr(sram_addr0), .sram_data_i(sram_data_i0), .sram_data_o(sram_data_o0),
        .sram_data_oe(sram_data_oe0), .sram_ce_n(sram_ce_n0), .sram_oe_n(sram_oe_n0),
        .sram_we_n(sram_we_n0), .sram_be_n(sram_be_n0)
    );

    // ---------------- instance 1: 8-bit SRAM, no wait states ----------------
    sram_bridge_if #(.BUS_DW(32)) if1 ();
    logic [18:0] sram_addr1;
    logic [7:0]  sram_data_i1, sram_data_o1;
    logic        sram_data_oe1, sram_ce_n1, sram_oe_n1, sram_we_n1;
    logic [0:0]  sram_be_n1;
    logic [7:0]  mem1 [0:255];

    assign sram_data_i1 = sram_oe_n1 ? 8'h00 : mem1[sram_addr1[7:0]];

    sram_bridge #(.BUS_DW(32), .SRAM_DW(8), .SRAM_AW(19), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .bus(if1),
        .sram_addr(sram_addr1), .sram_data_i(sram_data_i1), .sram_data_o(sram_data_o1),
        .sram_data_oe(sram_data_oe1), .sram_ce_n(sram_ce_n1), .sram_oe_n(sram_oe_n1),
        .sram_we_n(sram_we_n1), .sram_be_n(sram_be_n1)
    );

    // per-cycle traces (bit t / entry t = cycle Tt)
    logic [11:0] tr_ce, tr_we, tr_oe, tr_st, tr_dn, tr_doe;
    logic [18:0] tr_addr [0:11];
    logic [15:0] tr_do   [0:11];
    logic [1:0]  tr_be   [0:11];
    logic [31:0] tr_rd   [0:11];
    logic        seen_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rec0(input int t);
        tr_ce[t]   = sram_ce_n0;
        tr_we[t]   = sram_we_n0;
        tr_oe[t]   = sram_oe_n0;
        tr_st[t]   = if0.stallreq;
        tr_dn[t]   = if0.done;
        tr_doe[t]  = sram_data_oe0;
        tr_addr[t] = sram_addr0;
        tr_do[t]   = sram_data_o0;
        tr_be[t]   = sram_be_n0;
        tr_rd[t]   = if0.rdata;
        chk("we_oe_excl", {63'd0, (sram_we_n0 == 1'b0) && (sram_oe_n0 == 1'b0)}, 64'd0);
    endtask

    // Present one request on instance 0 and trace T0..T8; inputs are
    // scrambled after T1 to show the request is latched.
    task automatic run0(input logic we_i, input logic [3:0] sel_i,
                        input logic [31:0] addr_i, input logic [31:0] wdata_i);
        @(negedge clk);
        if0.en = 1'b1; if0.we = we_i; if0.sel = sel_i; if0.addr = addr_i; if0.wdata = wdata_i;
        #1; rec0(0);
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk); #1; rec0(t);
            if (t == 1) begin
                if0.addr = ~addr_i; if0.wdata = ~wdata_i; if0.sel = ~sel_i; if0.we = ~we_i;
            end
            if (tr_dn[t]) if0.en = 1'b0;
        end
        if0.en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if0.en = 1'b1; if0.we = 1'b0; if0.sel = 4'h0; if0.addr = 32'h0; if0.wdata = 32'h0;
        if1.en = 1'b0; if1.we = 1'b0; if1.sel = 4'h0; if1.addr = 32'h0; if1.wdata = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 8'h00;
        end
        mem0[8'h82] = 16'h1234; mem0[8'h83] = 16'hABCD;
        mem1[8'h40] = 8'h11; mem1[8'h41] = 8'h22; mem1[8'h42] = 8'h33; mem1[8'h43] = 8'h44;

        // reset with en=1
        @(negedge clk); @(negedge clk); #1;
        chk("rst_rdata", {32'd0, if0.rdata}, 64'd0);
        chk("rst_done", {63'd0, if0.done}, 64'd0);
        chk("rst_addr", {45'd0, sram_addr0}, 64'd0);
        chk("rst_data_o", {48'd0, sram_data_o0}, 64'd0);
        chk("rst_pins", {59'd0, sram_data_oe0, sram_ce_n0, sram_oe_n0, sram_we_n0, 1'b0}, {59'd0, 5'b01110});
        chk("rst_be_n", {62'd0, sram_be_n0}, 64'd3);
        rst = 1'b0; if0.en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_stall", {63'd0, if0.stallreq}, 64'd0);
        chk("idle_ce_n", {63'd0, sram_ce_n0}, 64'd1);

        // full-word write
        run0(1'b1, 4'b1111, 32'h0000_0104, 32'hDEAD_BEEF);
        chk("wr_we_n", {55'd0, tr_we[8:0]}, {55'd0, 9'b111001001});
        chk("wr_oe_n", {55'd0, tr_oe[8:0]}, {55'd0, 9'b111111111});
        chk("wr_ce_n", {55'd0, tr_ce[8:0]}, {55'd0, 9'b110000001});
        chk("wr_stall", {55'd0, tr_st[8:0]}, {55'd0, 9'b001111111});
        chk("wr_done", {55'd0, tr_dn[8:0]}, {55'd0, 9'b010000000});
        chk("wr_addr_b0", {45'd0, tr_addr[1]}, 64'h82);
        chk("wr_data_b0", {48'd0, tr_do[1]}, 64'hBEEF);
        chk("wr_be_b0", {62'd0, tr_be[1]}, 64'd0);
        chk("wr_addr_b1", {45'd0, tr_addr[4]}, 64'h83);
        chk("wr_data_b1", {48'd0, tr_do[5]}, 64'hDEAD);
        chk("wr_hold_data", {48'd0, tr_do[6]}, 64'hDEAD);
        chk("wr_hold_oe", {52'd0, tr_doe}, {52'd0, 12'b000001111110});

        // full-word read
        run0(1'b0, 4'b1111, 32'h0000_0104, 32'h0);
        chk("rd_oe_n", {55'd0, tr_oe[8:0]}, {55'd0, 9'b111001001});
        chk("rd_we_n", {55'd0, tr_we[8:0]}, {55'd0, 9'b111111111});
        chk("rd_done", {55'd0, tr_dn[8:0]}, {55'd0, 9'b010000000});
        chk("rd_rdata", {32'd0, tr_rd[7]}, 64'hABCD_1234);

        // single byte read, only beat 1 runs
        run0(1'b0, 4'b0100, 32'h0000_0106, 32'h0);
        chk("byte_clear", {32'd0, tr_rd[1]}, 64'd0);
        chk("byte_ce_n", {55'd0, tr_ce[8:0]}, {55'd0, 9'b111110001});
        chk("byte_addr", {45'd0, tr_addr[1]}, 64'h83);
        chk("byte_be_n", {60'd0, tr_be[1], tr_be[3]}, {60'd0, 4'b1010});
        chk("byte_done", {55'd0, tr_dn[8:0]}, {55'd0, 9'b000010000});
        chk("byte_rdata", {32'd0, tr_rd[4]}, 64'h00CD_0000);
        chk("byte_hold", {32'd0, tr_rd[8]}, 64'h00CD_0000);

        // no lanes enabled
        run0(1'b0, 4'b0000, 32'h0000_0104, 32'h0);
        chk("sel0_ce_n", {55'd0, tr_ce[8:0]}, {55'd0, 9'b111111111});
        chk("sel0_done", {55'd0, tr_dn[8:0]}, {55'd0, 9'b000000010});
        chk("sel0_stall", {55'd0, tr_st[8:0]}, {55'd0, 9'b000000001});
        chk("sel0_rdata", {32'd0, tr_rd[1]}, 64'd0);

        // reset in beat-1 ACCESS of a write
        @(negedge clk);
        if0.en = 1'b1; if0.we = 1'b1; if0.sel = 4'b1111; if0.addr = 32'h104; if0.wdata = 32'hDEAD_BEEF;
        repeat (4) @(negedge clk);
        #1;
        chk("mid_we_n", {63'd0, sram_we_n0}, 64'd0);
        chk("mid_addr", {45'd0, sram_addr0}, 64'h83);
        rst = 1'b1;
        #1;
        chk("mid_rst_pins", {60'd0, sram_ce_n0, sram_we_n0, sram_oe_n0, sram_data_oe0}, {60'd0, 4'b1110});
        chk("mid_rst_be", {62'd0, sram_be_n0}, 64'd3);
        if0.en = 1'b0;
        seen_done = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (t == 1) rst = 1'b0;
            #1;
            seen_done = seen_done | if0.done;
        end
        chk("mid_no_done", {63'd0, seen_done}, 64'd0);
        run0(1'b0, 4'b1111, 32'h0000_0104, 32'h0);
        chk("post_rst_done", {55'd0, tr_dn[8:0]}, {55'd0, 9'b010000000});
        chk("post_rst_rdata", {32'd0, tr_rd[7]}, 64'hABCD_1234);

        // 8-bit SRAM, zero wait states, four beats
        @(negedge clk);
        if1.en = 1'b1; if1.we = 1'b0; if1.sel = 4'b1111; if1.addr = 32'h42; if1.wdata = 32'h0;
        #1;
        tr_ce[0] = sram_ce_n1; tr_oe[0] = sram_oe_n1; tr_dn[0] = if1.done;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk); #1;
            tr_ce[t] = sram_ce_n1; tr_oe[t] = sram_oe_n1; tr_dn[t] = if1.done;
            tr_addr[t] = sram_addr1; tr_rd[t] = if1.rdata;
            if (if1.done) if1.en = 1'b0;
        end
        if1.en = 1'b0;
        chk("w8_ce_n", {53'd0, tr_ce[10:0]}, {53'd0, 11'b11000000001});
        chk("w8_oe_n", {53'd0, tr_oe[10:0]}, {53'd0, 11'b11101010101});
        chk("w8_done", {53'd0, tr_dn[10:0]}, {53'd0, 11'b01000000000});
        chk("w8_addr", {tr_addr[1][15:0], tr_addr[3][15:0], tr_addr[5][15:0], tr_addr[7][15:0]},
            64'h0040_0041_0042_0043);
        chk("w8_rdata", {32'd0, tr_rd[9]}, 64'h4433_2211);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Parametrised multi-beat bridge between the MEM-stage data port (en/we/sel/addr/wdata/rdata) and an external asynchronous SRAM narrower than the CPU bus.
- Splits each bus access into SRAM_DW-wide beats and skips beats with no enabled bytes.
- Inserts programmable wait states.
- Raises a stall request to stall_control until the access completes.

Parameters:
- BUS_DW, 32: CPU data width. Must be a multiple of SRAM_DW.
- SRAM_DW, 16: SRAM data width, one of 8, 16 or 32. SB = SRAM_DW/8 byte lanes per beat. BEATS = BUS_DW/SRAM_DW.
- SRAM_AW, 19: SRAM word-address width.
- WAIT_CYCLES, 1: extra ACCESS cycles per beat, range 0..15. Each beat's ACCESS phase lasts WAIT_CYCLES+1 cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  access request, held by the pipeline while stallreq=1
- we  in  1  1 = write, 0 = read
- sel  in  BUS_DW/8  byte enables; bit i selects byte i (little-endian)
- addr  in  32  byte address; low log2(BUS_DW/8) bits ignored
- wdata  in  BUS_DW  write data
- rdata  out  BUS_DW  read data, registered
- stallreq  out  1  pipeline stall request
- done  out  1  one-cycle completion pulse
- sram_addr  out  SRAM_AW  SRAM word address
- sram_data_i  in  SRAM_DW  SRAM read data
- sram_data_o  out  SRAM_DW  SRAM write data
- sram_data_oe  out  1  data pad output enable (tristate lives in top level)
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_be_n  out  SB  byte-lane enables, active low

Behaviour:
- Reset (async, any state): state=IDLE; rdata=0; done=0; sram_addr=0; sram_data_o=0; sram_data_oe=0; ce_n=oe_n=we_n=1; be_n=all 1.
- States: IDLE, ACCESS, RECOVER, DONE. Beat index k; wait counter wc (4 bits).
- IDLE:
  - en=1 latches addr, we, sel, wdata and clears rdata to 0.
  - Next state is ACCESS at the lowest k whose lane slice sel[k*SB +: SB] != 0, with wc=0.
  - If sel=0, next state is DONE.
- ACCESS:
  - Outputs: ce_n=0; be_n=~slice(k); sram_addr = aligned word base + k, where base = addr[SRAM_AW+log2(SB)-1 : log2(SB)] with the low log2(BEATS) bits of the base forced to 0.
  - Read: oe_n=0.
  - Write: we_n=0, data_oe=1, data_o=wdata[k*SRAM_DW +: SRAM_DW].
  - wc increments each cycle; at wc==WAIT_CYCLES, go to RECOVER.
  - Read capture on that same edge: rdata[k*SRAM_DW +: SRAM_DW] takes enabled-lane bytes of sram_data_i; disabled lanes stay 0.
- RECOVER (1 cycle):
  - ce_n=0; we_n=1; oe_n=1; sram_addr and be_n held.
  - Write: data_oe=1 and data_o held (hold time).
  - Next state: ACCESS at the next higher enabled beat (wc=0), else DONE.
- DONE: done=1 for exactly 1 cycle; SRAM pins idle; next state IDLE.
- stallreq (combinational) = (IDLE & en) | ACCESS | RECOVER. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Latency:
  - Each enabled beat costs WAIT_CYCLES+2 cycles.
  - done asserts at cycle 1 + sum(beat costs) after the acceptance cycle T0. With defaults and all bytes enabled, that is T7.
- Boundaries:
  - Input changes while busy are ignored because the request is latched.
  - en sampled in DONE is ignored; a request is accepted only in IDLE.
  - Beats with no enabled bytes are skipped entirely, with no SRAM cycle.
  - BEATS=1 gives a single beat.
  - rdata holds until the next acceptance.
  - Reset mid-beat deasserts all SRAM controls immediately, with no done pulse.
- sram_we_n is never low in the same cycle as sram_oe_n=0.

Test Plan:
- Reset with en=1 -> all outputs at reset values; after release, with en=0, state stays IDLE and stallreq=0.
- Write, defaults: addr=0x104, sel=4'b1111, wdata=0xDEADBEEF ->
  - beat0: sram_addr=0x82, data_o=0xBEEF, we_n low T1-T2.
  - beat1: sram_addr=0x83, data_o=0xDEAD, we_n low T4-T5.
  - stallreq=1 T0-T6; done=1 at T7 only.
- Read with model mem[0x82]=0x1234, mem[0x83]=0xABCD, sel=4'b1111 -> rdata=0xABCD1234 at T7; oe_n low T1-T2 and T4-T5; we_n stays 1.
- Byte read: addr=0x106, sel=4'b0100 -> only beat1 runs (sram_addr=0x83, be_n=2'b10, T1-T3); rdata=0x00CD0000; done at T4.
- sel=4'b0000 with en=1 -> no ce_n activity; done at T1; rdata=0.
- Reset during beat1 ACCESS of a write -> same cycle: ce_n=we_n=1, data_oe=0; done never pulses; a new request after reset completes normally.
- Parameter variant SRAM_DW=8, WAIT_CYCLES=0: 32-bit read -> 4 beats at word addresses base..base+3, done at T9.
